// File: rtl/regress_ctrl_pkg.sv
// regress_ctrl_pkg: shared constants, result widths and FSM state type for the regression controller
package regress_ctrl_pkg;

    localparam int N       = 256;
    localparam int ACC_TMO = 16;
    localparam int INV_TMO = 32;

    localparam int SMP_W  = 16;
    localparam int BANK_W = 2;
    localparam int IDX_W  = $clog2(N);
    localparam int ADDR_W = BANK_W + IDX_W;
    localparam int TMO_W  = $clog2(INV_TMO + 1);

    localparam int INV0_W = 32;
    localparam int INV1_W = 20;
    localparam int INV2_W = 21;
    localparam int XTY_W  = 33;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD,
        WAIT_ACC,
        INV,
        DONE
    } state_t;

endpackage

// File: rtl/regress_ctrl_if.sv
// regress_ctrl_if: job handshake, sample RAM, accumulator, inverter and result/status bundle
interface regress_ctrl_if;
    import regress_ctrl_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [BANK_W-1:0]   req_bank;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [SMP_W-1:0]    rd_x;
    logic [SMP_W-1:0]    rd_y;
    logic                acc_clr;
    logic                acc_start;
    logic [SMP_W-1:0]    acc_x;
    logic [SMP_W-1:0]    acc_y;
    logic                xtx_valid;
    logic                xty_valid;
    logic [XTY_W-1:0]    xty1;
    logic [XTY_W-1:0]    xty2;
    logic                inv_start;
    logic                inv_valid;
    logic [INV0_W-1:0]   inv0;
    logic [INV1_W-1:0]   inv1;
    logic [INV2_W-1:0]   inv2;
    logic [INV0_W-1:0]   res_inv0;
    logic [INV1_W-1:0]   res_inv1;
    logic [INV2_W-1:0]   res_inv2;
    logic [XTY_W-1:0]    res_xty1;
    logic [XTY_W-1:0]    res_xty2;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output req_valid, req_bank, rd_x, rd_y, xtx_valid, xty_valid, xty1, xty2,
               inv_valid, inv0, inv1, inv2,
        input  req_ready, rd_en, rd_addr, acc_clr, acc_start, acc_x, acc_y, inv_start,
               res_inv0, res_inv1, res_inv2, res_xty1, res_xty2, busy, done, err
    );

    modport slave (
        input  req_valid, req_bank, rd_x, rd_y, xtx_valid, xty_valid, xty1, xty2,
               inv_valid, inv0, inv1, inv2,
        output req_ready, rd_en, rd_addr, acc_clr, acc_start, acc_x, acc_y, inv_start,
               res_inv0, res_inv1, res_inv2, res_xty1, res_xty2, busy, done, err
    );

endinterface

// File: rtl/regress_ctrl_tmo.sv
// regress_tmo: shared timeout counter, zeroed by ld, flags the last allowed cycle of a wait window
module regress_tmo
    import regress_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [TMO_W-1:0] limit,
    output logic             expired
);

    logic [TMO_W-1:0] cnt;

    // count cycles spent in the current state, restarting from zero on every load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= ld ? '0 : cnt + 1'b1;
    end

    assign expired = cnt == limit - 1'b1;

endmodule

// File: rtl/regress_ctrl.sv
// regress_ctrl: sequences one regression job: clear, stream N samples, await sums, invert, report
module regress_ctrl
    import regress_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    regress_ctrl_if.slave bus
);

    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx;
    logic [BANK_W-1:0] bank;
    logic              rd_vld_q;
    logic              xtx_f, xty_f;
    logic              xtx_seen, xty_seen;
    logic              tmo_ld, tmo_exp, err_nx;
    logic [TMO_W-1:0]  tmo_lim;

    assign xtx_seen = xtx_f | bus.xtx_valid;
    assign xty_seen = xty_f | bus.xty_valid;
    assign tmo_ld   = state_nx != state;
    assign tmo_lim  = (state == INV) ? TMO_W'(INV_TMO) : TMO_W'(ACC_TMO);

    regress_tmo u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld      (tmo_ld),
        .limit   (tmo_lim),
        .expired (tmo_exp)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state; a late valid arriving in the last window cycle still wins over the timeout
    always_comb begin
        state_nx = state;
        err_nx   = 1'b0;
        case (state)
            IDLE:     state_nx = bus.req_valid ? CLR : IDLE;
            CLR:      state_nx = LOAD;
            LOAD:     state_nx = (idx == IDX_W'(N - 1)) ? WAIT_ACC : LOAD;
            WAIT_ACC: begin
                if (xtx_seen && xty_seen) state_nx = INV;
                else if (tmo_exp) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end
            end
            INV: begin
                if (bus.inv_valid) state_nx = DONE;
                else if (tmo_exp) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end
            end
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    assign bus.req_ready = state == IDLE;
    assign bus.busy      = state != IDLE;
    assign bus.done      = state == DONE;
    assign bus.acc_clr   = state == CLR;
    assign bus.rd_en     = state == LOAD;
    assign bus.acc_start = bus.rd_en && idx == '0;
    assign bus.rd_addr   = bus.rd_en ? {bank, idx} : '0;
    assign bus.acc_x     = rd_vld_q ? bus.rd_x : '0;
    assign bus.acc_y     = rd_vld_q ? bus.rd_y : '0;
    assign bus.inv_start = state == INV;

    // bank latch, read index and read-data-valid tracking for the sample stream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank     <= '0;
            idx      <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            if (state == IDLE && bus.req_valid) bank <= bus.req_bank;
            idx      <= (state == LOAD) ? idx + 1'b1 : '0;
            rd_vld_q <= state == LOAD;
        end
    end

    // sticky accumulator-ready flags, live only while waiting for the sums
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xtx_f <= 1'b0;
            xty_f <= 1'b0;
        end else begin
            xtx_f <= (state == WAIT_ACC && state_nx == WAIT_ACC) && xtx_seen;
            xty_f <= (state == WAIT_ACC && state_nx == WAIT_ACC) && xty_seen;
        end
    end

    // capture sums when the XTY flag first sets and inverter results on inv_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.res_xty1 <= '0;
            bus.res_xty2 <= '0;
            bus.res_inv0 <= '0;
            bus.res_inv1 <= '0;
            bus.res_inv2 <= '0;
        end else begin
            if (state == WAIT_ACC && bus.xty_valid && !xty_f) begin
                bus.res_xty1 <= bus.xty1;
                bus.res_xty2 <= bus.xty2;
            end
            if (state == INV && bus.inv_valid) begin
                bus.res_inv0 <= bus.inv0;
                bus.res_inv1 <= bus.inv1;
                bus.res_inv2 <= bus.inv2;
            end
        end
    end

    // error pulse lands in the first IDLE cycle after a timeout, so it never meets done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.err <= 1'b0;
        else        bus.err <= err_nx;
    end

endmodule

// File: doc/regress_ctrl.md
REGRESS_CTRL -- requirements
Module: regress_ctrl

Interface
REQ-001 Parameter N, 256, samples per regression job.
REQ-002 Parameter ACC_TMO, 16, max cycles in WAIT_ACC before error.
REQ-003 Parameter INV_TMO, 32, max cycles in INV before error.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid / req_ready  in / out  1 / 1  job request handshake.
REQ-007 req_bank  in  2  sample-RAM bank for the job.
REQ-008 rd_en / rd_addr  out / out  1 / 10  sample-RAM read port; rd_addr = {bank, idx[7:0]}.
REQ-009 rd_x / rd_y  in / in  16 / 16  RAM read data, valid one cycle after rd_en.
REQ-010 acc_clr / acc_start  out / out  1 / 1  accumulator synchronous clear pulse / start pulse, shared by XTX and XTY.
REQ-011 acc_x / acc_y  out / out  16 / 16  sample fed to accumulators.
REQ-012 xtx_valid / xty_valid  in / in  1 / 1  accumulator result-ready levels.
REQ-013 xty1 / xty2  in / in  33 / 33  XTY sums.
REQ-014 inv_start / inv_valid  out / in  1 / 1  inverter enable level / result-ready.
REQ-015 inv0 / inv1 / inv2  in  32 / 20 / 21  inverter results.
REQ-016 res_inv0 / res_inv1 / res_inv2 / res_xty1 / res_xty2  out  32 / 20 / 21 / 33 / 33  captured job results.
REQ-017 busy / done / err  out  1 / 1 / 1  status; done and err are one-cycle pulses.

Function
REQ-018 States IDLE, CLR, LOAD, WAIT_ACC, INV, DONE; req_ready = 1 only in IDLE.
REQ-019 IDLE -> CLR when req_valid & req_ready; req_bank latched in that cycle; requests are never accepted in any other state.
REQ-020 CLR lasts exactly 1 cycle with acc_clr = 1, then LOAD.
REQ-021 acc_start = 1 for exactly the first LOAD cycle only.
REQ-022 LOAD issues rd_en for exactly N consecutive cycles, idx 0..N-1 ascending; no gaps.
REQ-023 acc_x/acc_y = rd_x/rd_y on the N cycles following each rd_en; else 0.
REQ-024 Accepted at cycle A: acc_clr at A+1, acc_start and first rd_en at A+2, last rd_en at A+N+1, last sample on acc_x at A+N+2.
REQ-025 LOAD -> WAIT_ACC after the last rd_en cycle.
REQ-026 xtx_valid/xty_valid are sampled only in WAIT_ACC; each sets a sticky flag; flags clear on leaving WAIT_ACC.
REQ-027 Valids may arrive in either order or in the same cycle.
REQ-028 res_xty1/res_xty2 are loaded from xty1/xty2 in the cycle the xty flag sets.
REQ-029 WAIT_ACC -> INV the cycle after both flags are set.
REQ-030 WAIT_ACC -> IDLE with err pulse after ACC_TMO cycles without both flags set.
REQ-031 inv_start = 1 for every INV cycle and 0 otherwise.
REQ-032 On inv_valid = 1 in INV, res_inv0..2 are loaded from inv0..2 and the FSM goes to DONE.
REQ-033 INV -> IDLE with err pulse after INV_TMO cycles without inv_valid; res_inv* unchanged on timeout.
REQ-034 DONE lasts 1 cycle with done = 1, then IDLE.
REQ-035 busy = 1 in every state except IDLE.
REQ-036 err and done are never asserted in the same cycle.
REQ-037 res_* hold their value until overwritten by a later job.
REQ-038 A single shared timeout counter is used; it is zeroed on entry to WAIT_ACC and to INV.

Reset
REQ-039 rst_n low, at any time including mid-job: state IDLE; all outputs 0 except req_ready = 1; res_*, flags, counters and latched bank cleared.
REQ-040 First request is acceptable in the first cycle after rst_n deasserts.

Structure
REQ-041 Shared package holds the state enum, N, ACC_TMO, INV_TMO and the result widths (32/20/21/33).
REQ-042 One sub-module, regress_tmo, holds the loadable timeout counter; everything else stays in regress_ctrl.

Verification
REQ-043 Single job, bank 2, RAM x = idx, y = 1, acc models valid 3 cycles after last sample, inv valid 8 cycles into INV -> rd_addr 0x200..0x2FF contiguous; res_xty1 = 256; done at the expected cycle.
REQ-044 xty_valid 5 cycles before xtx_valid, then a second run with both in the same cycle -> INV entered exactly 1 cycle after the later valid in both runs.
REQ-045 Accumulators never assert valid -> err pulse ACC_TMO cycles after WAIT_ACC entry; inv_start never asserted; IDLE and req_ready = 1.
REQ-046 inv_valid never asserted -> err after 32 INV cycles; res_inv* keep the previous job's values.
REQ-047 req_valid held high through a whole job -> second job accepted only in the IDLE cycle after done; exactly 256 rd_en per job.
REQ-048 rst_n pulsed low at LOAD idx 100 -> outputs reset immediately; the next job restarts at idx 0 with acc_clr.
